// File: rtl/sc_io_pkg.sv
// ---- sc_io_pkg : shared IO-space addresses, UART register layout and TX FSM encoding (rev 1.0) ----
`default_nettype none

package sc_io_pkg;

  localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
  localparam logic [31:0] LED_BASE    = 32'hFFFF_0000;
  localparam logic [31:0] SWITCH_BASE = 32'hFFFF_0004;
  localparam logic [31:0] UART_BASE   = 32'hFFFF_0010;

  // Byte offsets inside the UART window; the decoder only looks at [3:2].
  localparam logic [3:0] UART_DATA   = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] uart_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf);
    logic [31:0] s;
    s           = '0;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_fifo.sv
// ---- sc_fifo : synchronous FIFO with fall-through read data (rev 1.0) ----
`default_nettype none

module sc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a push is judged before any same-cycle pop.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/sc_uart_tx.sv
// ---- sc_uart_tx : memory-mapped 8N1 UART transmitter with byte FIFO (rev 1.0) ----
`default_nettype none

module sc_uart_tx
  import sc_io_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        txd
);

  localparam int             DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  logic       wr;
  logic [1:0] reg_sel;
  logic       data_wr;
  logic       status_wr;
  logic       overflow;
  logic       unused_bits;

  logic       pop;
  logic [7:0] fifo_dout;
  logic       full;
  logic       empty;

  tx_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tick;

  assign reg_sel     = addr[3:2];
  assign wr          = sel & we;
  assign data_wr     = wr && (reg_sel == UART_DATA[3:2]);
  assign status_wr   = wr && (reg_sel == UART_STATUS[3:2]);
  assign unused_bits = ^{datain[31:8], addr[1:0]};

  sc_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (data_wr),
    .pop    (pop),
    .din    (datain[7:0]),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty)
  );

  // A store to a full FIFO is dropped inside sc_fifo; only the sticky flag records it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)               overflow <= 1'b0;
    else if (data_wr && full)  overflow <= 1'b1;
    else if (status_wr)        overflow <= 1'b0;
  end

  always_comb begin
    dataout = '0;
    if (reg_sel == UART_STATUS[3:2])
      dataout = uart_status(full, empty, state != TX_IDLE, overflow);
  end

  assign tick = (cnt == '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= TX_IDLE;
      cnt     <= CNT_MAX;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      TX_IDLE: begin
        cnt_nxt = CNT_MAX;
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = fifo_dout;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          cnt_nxt   = CNT_MAX;
          bit_nxt   = '0;
          state_nxt = TX_DATA;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      TX_DATA: begin
        if (tick) begin
          cnt_nxt   = CNT_MAX;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nxt = TX_STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      TX_STOP: begin
        if (tick) begin
          cnt_nxt = CNT_MAX;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = fifo_dout;
            state_nxt = TX_START;
          end else begin
            state_nxt = TX_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = shift[0];
      default:  txd = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_uart_tx.sv
// ---- tb_sc_uart_tx : directed self-checking bench for sc_uart_tx (rev 1.0) ----
`default_nettype none

module tb_sc_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;

  logic        clock  = 1'b0;
  logic        resetn = 1'b0;
  logic        sel    = 1'b0;
  logic        we     = 1'b0;
  logic [3:0]  addr   = 4'h4;
  logic [31:0] datain = 32'h0;
  logic [31:0] dataout;
  logic        txd;

  int errors    = 0;
  int checks    = 0;
  int rst_count = 0;
  int base;
  int low_cnt;
  logic [7:0] rx_q [$];
  logic [7:0] exp_b [8];
  logic [7:0] mon_byte;
  int         mon_rc;

  always #5 clock = ~clock;

  sc_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .DEPTH  (DEPTH)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .datain  (datain),
    .dataout (dataout),
    .txd     (txd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-clock store; upper data bits carry junk that must be ignored.
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    sel    = 1'b1;
    we     = 1'b1;
    addr   = a;
    datain = {24'hABCDEF, d};
    @(posedge clock);
    #1;
    sel    = 1'b0;
    we     = 1'b0;
    addr   = 4'h4;
    datain = 32'h0;
  endtask

  // Expects the next negedge to be the first clock of a start bit.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    logic [9:0] samp;
    logic       busy_all;
    bits     = {1'b1, b, 1'b0};
    busy_all = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < DIV; j++) begin
        @(negedge clock);
        samp[j] = txd;
        if (dataout[2] !== 1'b1) busy_all = 1'b0;
      end
      check($sformatf("%s bit%0d", tag, k), 32'(samp), bits[k] ? 32'h3FF : 32'h0);
    end
    check({tag, " busy"}, 32'(busy_all), 32'h1);
  endtask

  task automatic check_rx(input int b, input int n, input string tag);
    check({tag, " count"}, 32'(rx_q.size() - b), 32'(n));
    for (int i = 0; i < n; i++)
      if (b + i < rx_q.size())
        check($sformatf("%s byte%0d", tag, i), 32'(rx_q[b + i]), 32'(exp_b[i]));
  endtask

  always @(negedge resetn) rst_count++;

  // Line receiver: samples mid-bit, discards any frame that a reset interrupted.
  initial begin
    forever begin
      @(negedge clock);
      if (resetn === 1'b1 && txd === 1'b0) begin
        mon_rc = rst_count;
        repeat (DIV / 2 - 1) @(negedge clock);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(negedge clock);
          mon_byte[k] = txd;
        end
        repeat (DIV) @(negedge clock);
        if (txd === 1'b1 && mon_rc == rst_count) rx_q.push_back(mon_byte);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    @(negedge clock);
    check("reset txd", 32'(txd), 32'h1);
    check("reset status", dataout, 32'h2);
    addr = 4'h0;
    #1 check("reset data read", dataout, 32'h0);
    addr = 4'h8;
    #1 check("reset reserved read", dataout, 32'h0);
    addr = 4'h4;

    // Single byte
    base = rx_q.size();
    bus_write(4'h0, 8'hA5);
    @(negedge clock);
    check("single txd before pop", 32'(txd), 32'h1);
    check("single status before pop", dataout, 32'h0);
    check_frame(8'hA5, "single");
    @(negedge clock);
    check("single idle status", dataout, 32'h2);
    check("single idle txd", 32'(txd), 32'h1);
    exp_b[0] = 8'hA5;
    check_rx(base, 1, "single rx");

    // Back-to-back
    base = rx_q.size();
    bus_write(4'h0, 8'h55);
    bus_write(4'h0, 8'h0F);
    check_frame(8'h55, "b2b f1");
    check_frame(8'h0F, "b2b f2");
    @(negedge clock);
    check("b2b idle status", dataout, 32'h2);

    // Overflow
    base = rx_q.size();
    for (int i = 1; i <= 6; i++) bus_write(4'h0, 8'(i));
    @(negedge clock);
    check("ovf status", dataout, 32'hD);
    bus_write(4'h8, 8'hFF);
    @(negedge clock);
    check("ovf reserved write ignored", dataout, 32'hD);
    bus_write(4'h4, 8'h00);
    @(negedge clock);
    check("ovf cleared", dataout, 32'h5);
    repeat (600) @(negedge clock);
    check("ovf idle status", dataout, 32'h2);
    for (int i = 0; i < 5; i++) exp_b[i] = 8'(i + 1);
    check_rx(base, 5, "ovf rx");

    // Push on the last STOP clock with two bytes queued
    base = rx_q.size();
    bus_write(4'h0, 8'h11);
    bus_write(4'h0, 8'h22);
    bus_write(4'h0, 8'h33);
    repeat (98) @(posedge clock);
    @(negedge clock);
    check("pp last stop txd", 32'(txd), 32'h1);
    check("pp status before", dataout, 32'h4);
    bus_write(4'h0, 8'h44);
    @(negedge clock);
    check("pp next start txd", 32'(txd), 32'h0);
    check("pp status after", dataout, 32'h4);
    bus_write(4'h0, 8'h55);
    bus_write(4'h0, 8'h66);
    @(negedge clock);
    check("pp count was two", dataout, 32'h5);
    repeat (700) @(negedge clock);
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    exp_b[3] = 8'h44; exp_b[4] = 8'h55; exp_b[5] = 8'h66;
    check_rx(base, 6, "pp rx");

    // Reset during data bit 3
    base = rx_q.size();
    bus_write(4'h0, 8'hF0);
    bus_write(4'h0, 8'h77);
    bus_write(4'h0, 8'h88);
    repeat (43) @(posedge clock);
    #2;
    check("mid bit3 txd", 32'(txd), 32'h0);
    resetn = 1'b0;
    #1 check("async reset txd", 32'(txd), 32'h1);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    @(negedge clock);
    check("post reset status", dataout, 32'h2);
    check("post reset txd", 32'(txd), 32'h1);
    low_cnt = 0;
    repeat (300) begin
      @(negedge clock);
      if (txd !== 1'b1) low_cnt++;
    end
    check("no frames after reset", 32'(low_cnt), 32'h0);
    check_rx(base, 0, "reset rx");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
